hall_decoder: RTL and testbench
===============================

Name: hall_decoder

Overview:
- Feedback-side companion to the BLDC commutation logic. Samples the 3-bit Hall sensor bus from a motor (dribbler or drive wheel), filters glitches and validates the code sequence.
- Outputs rotation direction, a signed commutation-step position count, the step period in clock cycles, and stall/fault flags.
- Results feed the speed loop and the brake/enable decision.

Parameters:
FILT_CYCLES, 8, consecutive stable synchronized samples required to accept a new Hall code (>=1)
PERIOD_W, 24, width of the step-period counter and period output
POS_W, 16, width of the signed position counter
STALL_CYCLES, 1000000, cycles without a valid step before stall is declared (< 2^PERIOD_W)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active high
hall_in  input  3  raw Hall bus {H3,H2,H1}, asynchronous to clk
clr_pos  input  1  synchronous clear of position counter (and error counter when enabled)
hall_state  output  3  filtered, accepted Hall code
step  output  1  one-cycle pulse on each valid commutation step
dir  output  1  direction of last valid step: 1 forward, 0 reverse
position  output  POS_W  signed step count, two's complement
period  output  PERIOD_W  cycles between the last two same-direction valid steps
period_valid  output  1  period holds a valid measurement
stalled  output  1  no valid step for STALL_CYCLES cycles
hall_fault  output  1  accepted code is 0 or 7
seq_err  output  1  one-cycle pulse on an illegal transition

Behaviour:
- Reset values: hall_state=0, step=0, dir=1, position=0, period=0, period_valid=0, stalled=0, hall_fault=0, seq_err=0. Period counter=0, filter counter=0, FSM=INIT.
- Synchronizer: 2 flops on hall_in. Filter: counter clears whenever the synchronized value differs from the previous sample. The code is accepted when it differs from hall_state and has been stable FILT_CYCLES cycles. Latency from a stable hall_in change to hall_state update is FILT_CYCLES+2 edges. Pulses shorter than FILT_CYCLES are discarded.
- Forward sequence: 1->3->2->6->4->5->1. Reverse is the inverse.
- FSM states:
  - INIT: first accepted code loads hall_state. No step, no seq_err. Go to RUN if the code is 1..6, else FAULT.
  - RUN, accepted code is the forward successor: step=1, dir=1, position+1.
  - RUN, accepted code is the reverse successor: step=1, dir=0, position-1.
  - RUN, accepted code is another valid code (two-step jump): seq_err=1, no position change, period counter restarts, period_valid=0.
  - RUN, accepted code is 0 or 7: hall_fault=1, seq_err=1, go to FAULT.
  - FAULT: hall_fault=1. The next accepted valid code returns to RUN without a step (same as INIT), period_valid=0, period counter restarts.
- Period counter:
  - Increments every cycle in RUN and saturates at all-ones.
  - On a valid step with the same dir as the previous step, and not stalled: period<=counter+1, period_valid<=1.
  - On a direction reversal, or the first step after INIT/FAULT/stall: period unchanged, period_valid<=0.
  - The counter clears on every valid step.
- Stall: stalled=1 and period_valid=0 when the counter reaches STALL_CYCLES. Cleared by the next valid step; that step does not latch period.
- Position wraps modulo 2^POS_W with no saturation.
- clr_pos with a simultaneous step: position=0 (clear wins). dir, period and step still update.
- Reset mid-operation: all state returns to reset values immediately. The first code after reset goes through INIT.

Optional Feature:
- Macro HALL_ERR_CNT_EN.
- Defined: adds output err_cnt [7:0]. It increments on each seq_err pulse and saturates at 255. It resets to 0 and is cleared by clr_pos. If clr_pos coincides with seq_err, the result is 0.
- Undefined: no err_cnt port and no counter logic; all other behaviour identical.

Test Plan:
- Reset, hold hall_in=1, then drive 3,2,6,4,5,1 every 100 cycles (FILT_CYCLES=8): hall_state=1 after 10 edges with no step. Then 6 step pulses, position=6, dir=1, period_valid=1 from the 2nd step, period=100.
- From RUN at code 1, drive 5,4,6: position decrements 3, dir=0. The first reverse step gives period_valid=0; later steps give period=step spacing.
- Glitch: at code 1, pulse hall_in=3 for 5 cycles, then back to 1: hall_state stays 1, no step, no seq_err.
- Jump 1->2: seq_err pulse, position unchanged, period_valid=0. Then drive 7: hall_fault=1, FSM=FAULT. Then drive 6: hall_fault=0, no step. Then drive 4: step, position+1.
- Hold a code for STALL_CYCLES (set 1000): stalled=1, period_valid=0 at cycle 1000. The next step clears stalled and leaves period_valid=0.
- Position at 32767, forward step: position=-32768. Assert clr_pos on the same cycle as a step: position=0, step=1. With HALL_ERR_CNT_EN, 300 seq_err events: err_cnt=255.

Source files
------------

// File: rtl/hall_decoder.sv
// Hall sensor decoder: synchronizes and glitch-filters the 3-bit Hall bus,
// then validates the commutation sequence. Outputs direction, a signed step
// position, the step period and stall/fault flags.
// Optional feature: define HALL_ERR_CNT_EN to add an 8-bit saturating
// sequence-error counter output (err_cnt).
module hall_decoder #(
  parameter int unsigned FILT_CYCLES  = 8,
  parameter int unsigned PERIOD_W     = 24,
  parameter int unsigned POS_W        = 16,
  parameter int unsigned STALL_CYCLES = 1000000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [2:0]              hall_in,
  input  logic                    clr_pos,
  output logic [2:0]              hall_state,
  output logic                    step,
  output logic                    dir,
  output logic signed [POS_W-1:0] position,
  output logic [PERIOD_W-1:0]     period,
  output logic                    period_valid,
  output logic                    stalled,
  output logic                    hall_fault,
  output logic                    seq_err
`ifdef HALL_ERR_CNT_EN
  ,
  output logic [7:0]              err_cnt
`endif
);

  localparam int unsigned FCNT_W = $clog2(FILT_CYCLES + 1);

  typedef enum logic [1:0] {S_INIT, S_RUN, S_FAULT} state_t;

  state_t              state_q, state_d;
  logic [2:0]          sync1, sync2;
  logic [2:0]          cand;
  logic [FCNT_W-1:0]   fcnt, fcnt_n;
  logic                accept;
  logic [PERIOD_W-1:0] pcnt, pcnt_d, pcnt_inc;
  logic                have_ref, ref_d;

  logic [2:0]              hs_d;
  logic                    step_d, dir_d, pv_d, stalled_d, fault_d, serr_d;
  logic signed [POS_W-1:0] pos_d;
  logic [PERIOD_W-1:0]     per_d;

  // Forward successor in the sequence 1-3-2-6-4-5
  function automatic logic [2:0] fwd_of(input logic [2:0] c);
    case (c)
      3'd1:    fwd_of = 3'd3;
      3'd3:    fwd_of = 3'd2;
      3'd2:    fwd_of = 3'd6;
      3'd6:    fwd_of = 3'd4;
      3'd4:    fwd_of = 3'd5;
      3'd5:    fwd_of = 3'd1;
      default: fwd_of = c;
    endcase
  endfunction

  // Reverse successor (inverse of fwd_of)
  function automatic logic [2:0] rev_of(input logic [2:0] c);
    case (c)
      3'd1:    rev_of = 3'd5;
      3'd5:    rev_of = 3'd4;
      3'd4:    rev_of = 3'd6;
      3'd6:    rev_of = 3'd2;
      3'd2:    rev_of = 3'd3;
      3'd3:    rev_of = 3'd1;
      default: rev_of = c;
    endcase
  endfunction

  function automatic logic is_valid(input logic [2:0] c);
    is_valid = (c != 3'd0) && (c != 3'd7);
  endfunction

  // Two-flop synchronizer for the asynchronous Hall bus
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 3'd0;
      sync2 <= 3'd0;
    end else begin
      sync1 <= hall_in;
      sync2 <= sync1;
    end
  end

  // Stability run length including the current sample; new code accepted on the FILT_CYCLES-th
  always_comb begin
    if (sync2 != cand)                           fcnt_n = FCNT_W'(1);
    else if (fcnt == FCNT_W'(FILT_CYCLES))       fcnt_n = fcnt;
    else                                         fcnt_n = fcnt + FCNT_W'(1);
    accept = (fcnt_n >= FCNT_W'(FILT_CYCLES)) && (sync2 != hall_state);
  end

  // Glitch filter sample/run-length registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cand <= 3'd0;
      fcnt <= '0;
    end else begin
      cand <= sync2;
      fcnt <= fcnt_n;
    end
  end

  // Saturating increment of the period counter
  always_comb begin
    pcnt_inc = (pcnt == '1) ? pcnt : pcnt + PERIOD_W'(1);
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_INIT;
    else     state_q <= state_d;
  end

  // Next-state and next-output decode
  always_comb begin
    state_d   = state_q;
    hs_d      = hall_state;
    step_d    = 1'b0;
    dir_d     = dir;
    pos_d     = position;
    per_d     = period;
    pv_d      = period_valid;
    stalled_d = stalled;
    fault_d   = hall_fault;
    serr_d    = 1'b0;
    pcnt_d    = '0;
    ref_d     = have_ref;

    unique case (state_q)
      S_INIT, S_FAULT: begin
        // First accepted valid code only re-synchronizes; no step is counted
        if (accept) begin
          hs_d = sync2;
          if (is_valid(sync2)) begin
            state_d = S_RUN;
            fault_d = 1'b0;
            pv_d    = 1'b0;
            ref_d   = 1'b0;
          end else begin
            state_d = S_FAULT;
            fault_d = 1'b1;
          end
        end
      end
      S_RUN: begin
        pcnt_d = pcnt_inc;
        if (accept) begin
          hs_d   = sync2;
          pcnt_d = '0;
          if ((sync2 == fwd_of(hall_state)) || (sync2 == rev_of(hall_state))) begin
            step_d    = 1'b1;
            dir_d     = (sync2 == fwd_of(hall_state));
            pos_d     = dir_d ? position + POS_W'(1) : position - POS_W'(1);
            stalled_d = 1'b0;
            ref_d     = 1'b1;
            // Period only meaningful between two same-direction steps with no stall between
            if (have_ref && (dir_d == dir) && !stalled) begin
              per_d = pcnt_inc;
              pv_d  = 1'b1;
            end else begin
              pv_d  = 1'b0;
            end
          end else begin
            serr_d = 1'b1;
            pv_d   = 1'b0;
            ref_d  = 1'b0;
            if (!is_valid(sync2)) begin
              fault_d = 1'b1;
              state_d = S_FAULT;
            end
          end
        end else if (pcnt == PERIOD_W'(STALL_CYCLES - 1)) begin
          stalled_d = 1'b1;
          pv_d      = 1'b0;
        end
      end
      default: state_d = S_INIT;
    endcase

    // Clear wins over a coincident step
    if (clr_pos) pos_d = '0;
  end

  // Registered outputs and period bookkeeping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hall_state   <= 3'd0;
      step         <= 1'b0;
      dir          <= 1'b1;
      position     <= '0;
      period       <= '0;
      period_valid <= 1'b0;
      stalled      <= 1'b0;
      hall_fault   <= 1'b0;
      seq_err      <= 1'b0;
      pcnt         <= '0;
      have_ref     <= 1'b0;
    end else begin
      hall_state   <= hs_d;
      step         <= step_d;
      dir          <= dir_d;
      position     <= pos_d;
      period       <= per_d;
      period_valid <= pv_d;
      stalled      <= stalled_d;
      hall_fault   <= fault_d;
      seq_err      <= serr_d;
      pcnt         <= pcnt_d;
      have_ref     <= ref_d;
    end
  end

`ifdef HALL_ERR_CNT_EN
  // Saturating sequence-error counter; clear wins over a coincident error
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                               err_cnt <= 8'd0;
    else if (clr_pos)                      err_cnt <= 8'd0;
    else if (serr_d && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;
  end
`endif

endmodule

// File: tb/tb_hall_decoder.sv
// Self-checking bench for hall_decoder: directed vector table, hand-written
// multi-cycle sequences, and randomized stimulus against a reference model.
module tb_hall_decoder;

  localparam int FILT  = 8;
  localparam int PW    = 24;
  localparam int POSW  = 8;
  localparam int STALL = 1000;

  logic            clk = 1'b0;
  logic            rst;
  logic [2:0]      hall_in;
  logic            clr_pos;
  logic [2:0]      hall_state;
  logic            step, dir;
  logic [POSW-1:0] position;
  logic [PW-1:0]   period;
  logic            period_valid, stalled, hall_fault, seq_err;
`ifdef HALL_ERR_CNT_EN
  logic [7:0]      err_cnt;
`endif

  hall_decoder #(
    .FILT_CYCLES(FILT), .PERIOD_W(PW), .POS_W(POSW), .STALL_CYCLES(STALL)
  ) dut (
    .clk(clk), .rst(rst), .hall_in(hall_in), .clr_pos(clr_pos),
    .hall_state(hall_state), .step(step), .dir(dir), .position(position),
    .period(period), .period_valid(period_valid), .stalled(stalled),
    .hall_fault(hall_fault), .seq_err(seq_err)
`ifdef HALL_ERR_CNT_EN
    , .err_cnt(err_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int nsteps = 0;
  int nserr  = 0;
  bit cmp_model = 1'b0;

  logic [2:0] seq [6] = '{3'd1, 3'd3, 3'd2, 3'd6, 3'd4, 3'd5};

  // Reference model state
  int         m_k, m_pos, m_last, m_period, m_errc, m_mode; // mode: 0 init, 1 run, 2 fault
  logic [2:0] m_hs;
  logic       m_dir, m_ref, m_pv, m_stalled, m_fault, m_step, m_serr;
  logic [2:0] m_hq [$];
  logic [2:0] m_sq [$];

  typedef struct {
    logic [2:0] code;
    int         hold;
    logic [2:0] hs;
    int         steps;
    int         serrs;
    int         pos;
    logic       dir;
    logic       pv;
    int         period;
    logic       fault;
    logic       stalled;
  } vec_t;
  vec_t vt [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  function automatic logic [POSW-1:0] pw(input int x);
    logic [31:0] t;
    t = x;
    return t[POSW-1:0];
  endfunction

  function automatic int idx_of(input logic [2:0] c);
    for (int i = 0; i < 6; i++) if (seq[i] == c) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_k = 0; m_pos = 0; m_last = 0; m_period = 0; m_errc = 0; m_mode = 0;
    m_hs = 3'd0; m_dir = 1'b1; m_ref = 1'b0; m_pv = 1'b0; m_stalled = 1'b0;
    m_fault = 1'b0; m_step = 1'b0; m_serr = 1'b0;
    m_hq.delete(); m_sq.delete();
  endtask

  // One clock edge of the reference behaviour, given the inputs seen at that edge
  task automatic model_edge(input logic [2:0] h, input logic c);
    int run, a, b, d;
    logic [2:0] samp;
    logic newdir;
    m_k++; m_step = 1'b0; m_serr = 1'b0;
    m_hq.push_back(h);
    if (m_hq.size() > 3) void'(m_hq.pop_front());
    samp = (m_hq.size() == 3) ? m_hq[0] : 3'd0;
    m_sq.push_back(samp);
    if (m_sq.size() > FILT) void'(m_sq.pop_front());
    run = 0;
    for (int i = m_sq.size() - 1; i >= 0; i--) begin
      if (m_sq[i] != samp) break;
      run++;
    end
    if (run >= FILT && samp != m_hs) begin
      a = idx_of(m_hs); b = idx_of(samp); d = (b - a + 6) % 6;
      if (m_mode != 1) begin
        if (b >= 0) begin
          m_mode = 1; m_fault = 1'b0; m_pv = 1'b0; m_ref = 1'b0; m_last = m_k;
        end else begin
          m_mode = 2; m_fault = 1'b1;
        end
      end else if (b >= 0 && (d == 1 || d == 5)) begin
        newdir = (d == 1);
        if (m_ref && newdir == m_dir && !m_stalled) begin
          m_period = m_k - m_last; m_pv = 1'b1;
        end else m_pv = 1'b0;
        m_dir = newdir; m_pos += newdir ? 1 : -1; m_ref = 1'b1;
        m_stalled = 1'b0; m_last = m_k; m_step = 1'b1;
      end else begin
        m_serr = 1'b1; m_pv = 1'b0; m_ref = 1'b0; m_last = m_k;
        if (b < 0) begin m_mode = 2; m_fault = 1'b1; end
      end
      m_hs = samp;
    end else if (m_mode == 1 && (m_k - m_last) == STALL) begin
      m_stalled = 1'b1; m_pv = 1'b0;
    end
    if (c) m_pos = 0;
    if (c) m_errc = 0;
    else if (m_serr && m_errc < 255) m_errc++;
  endtask

  task automatic model_compare();
    check($sformatf("rnd@%0d hall_state", m_k), hall_state, m_hs);
    check($sformatf("rnd@%0d step", m_k), step, m_step);
    check($sformatf("rnd@%0d dir", m_k), dir, m_dir);
    check($sformatf("rnd@%0d position", m_k), position, pw(m_pos));
    check($sformatf("rnd@%0d period", m_k), period, m_period);
    check($sformatf("rnd@%0d period_valid", m_k), period_valid, m_pv);
    check($sformatf("rnd@%0d stalled", m_k), stalled, m_stalled);
    check($sformatf("rnd@%0d hall_fault", m_k), hall_fault, m_fault);
    check($sformatf("rnd@%0d seq_err", m_k), seq_err, m_serr);
`ifdef HALL_ERR_CNT_EN
    check($sformatf("rnd@%0d err_cnt", m_k), err_cnt, m_errc);
`endif
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge
  task automatic tick();
    logic [2:0] h;
    logic c, r;
    h = hall_in; c = clr_pos; r = rst;
    @(posedge clk);
    #1;
    if (r) model_reset();
    else   model_edge(h, c);
    if (step)    nsteps++;
    if (seq_err) nserr++;
    if (cmp_model) model_compare();
  endtask

  task automatic hold(input logic [2:0] code, input int n);
    hall_in = code;
    repeat (n) tick();
  endtask

  initial begin
    #3ms;
    errors++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    logic [2:0] cur;
    int n, r, hl;

    // Directed table: code, hold, hs, steps, serrs, pos, dir, pv, period, fault, stalled
    vt.push_back('{3'd1,  90, 3'd1, 0, 0, 0, 1'b1, 1'b0,   0, 1'b0, 1'b0});
    vt.push_back('{3'd3, 100, 3'd3, 1, 0, 1, 1'b1, 1'b0,   0, 1'b0, 1'b0});
    vt.push_back('{3'd2, 100, 3'd2, 1, 0, 2, 1'b1, 1'b1, 100, 1'b0, 1'b0});
    vt.push_back('{3'd6, 100, 3'd6, 1, 0, 3, 1'b1, 1'b1, 100, 1'b0, 1'b0});
    vt.push_back('{3'd4, 100, 3'd4, 1, 0, 4, 1'b1, 1'b1, 100, 1'b0, 1'b0});
    vt.push_back('{3'd5, 100, 3'd5, 1, 0, 5, 1'b1, 1'b1, 100, 1'b0, 1'b0});
    vt.push_back('{3'd1, 100, 3'd1, 1, 0, 6, 1'b1, 1'b1, 100, 1'b0, 1'b0});
    vt.push_back('{3'd5,  60, 3'd5, 1, 0, 5, 1'b0, 1'b0, 100, 1'b0, 1'b0});
    vt.push_back('{3'd4,  60, 3'd4, 1, 0, 4, 1'b0, 1'b1,  60, 1'b0, 1'b0});
    vt.push_back('{3'd6,  60, 3'd6, 1, 0, 3, 1'b0, 1'b1,  60, 1'b0, 1'b0});
    vt.push_back('{3'd2,  60, 3'd2, 1, 0, 2, 1'b0, 1'b1,  60, 1'b0, 1'b0});
    vt.push_back('{3'd3,  60, 3'd3, 1, 0, 1, 1'b0, 1'b1,  60, 1'b0, 1'b0});
    vt.push_back('{3'd1,  60, 3'd1, 1, 0, 0, 1'b0, 1'b1,  60, 1'b0, 1'b0});
    vt.push_back('{3'd3,   5, 3'd1, 0, 0, 0, 1'b0, 1'b1,  60, 1'b0, 1'b0});
    vt.push_back('{3'd1,  30, 3'd1, 0, 0, 0, 1'b0, 1'b1,  60, 1'b0, 1'b0});
    vt.push_back('{3'd2,  30, 3'd2, 0, 1, 0, 1'b0, 1'b0,  60, 1'b0, 1'b0});
    vt.push_back('{3'd7,  30, 3'd7, 0, 1, 0, 1'b0, 1'b0,  60, 1'b1, 1'b0});
    vt.push_back('{3'd6,  30, 3'd6, 0, 0, 0, 1'b0, 1'b0,  60, 1'b0, 1'b0});
    vt.push_back('{3'd4,  30, 3'd4, 1, 0, 1, 1'b1, 1'b0,  60, 1'b0, 1'b0});

    // Reset values
    rst = 1'b1; hall_in = 3'd1; clr_pos = 1'b0;
    model_reset();
    repeat (3) tick();
    check("reset hall_state", hall_state, 3'd0);
    check("reset step", step, 1'b0);
    check("reset dir", dir, 1'b1);
    check("reset position", position, '0);
    check("reset period", period, '0);
    check("reset period_valid", period_valid, 1'b0);
    check("reset stalled", stalled, 1'b0);
    check("reset hall_fault", hall_fault, 1'b0);
    check("reset seq_err", seq_err, 1'b0);
`ifdef HALL_ERR_CNT_EN
    check("reset err_cnt", err_cnt, 8'd0);
`endif
    rst = 1'b0;

    // Acceptance latency of FILT+2 edges, first code through INIT gives no step
    nsteps = 0;
    repeat (FILT + 1) tick();
    check("latency before", hall_state, 3'd0);
    tick();
    check("latency at", hall_state, 3'd1);
    check("init no step", nsteps, 0);

    // Directed table
    foreach (vt[i]) begin
      nsteps = 0; nserr = 0;
      hold(vt[i].code, vt[i].hold);
      check($sformatf("row%0d hall_state", i), hall_state, vt[i].hs);
      check($sformatf("row%0d steps", i), nsteps, vt[i].steps);
      check($sformatf("row%0d seq_errs", i), nserr, vt[i].serrs);
      check($sformatf("row%0d position", i), position, pw(vt[i].pos));
      check($sformatf("row%0d dir", i), dir, vt[i].dir);
      check($sformatf("row%0d period_valid", i), period_valid, vt[i].pv);
      check($sformatf("row%0d period", i), period, vt[i].period);
      check($sformatf("row%0d hall_fault", i), hall_fault, vt[i].fault);
      check($sformatf("row%0d stalled", i), stalled, vt[i].stalled);
    end

    // Stall: exactly STALL cycles after a step with no further step
    hall_in = 3'd5;
    n = 0;
    while (!step && n < 20) begin tick(); n++; end
    check("stall step seen", step, 1'b1);
    n = 0;
    while (!stalled && n < STALL + 100) begin tick(); n++; end
    check("stall delay", n, STALL);
    check("stall period_valid", period_valid, 1'b0);
    nsteps = 0;
    hold(3'd1, 20);
    check("post-stall steps", nsteps, 1);
    check("post-stall stalled", stalled, 1'b0);
    check("post-stall period_valid", period_valid, 1'b0);
    hold(3'd3, 20);
    check("post-stall2 period_valid", period_valid, 1'b1);
    check("post-stall2 period", period, 20);
    check("post-stall2 position", position, pw(4));

    // Asynchronous reset mid-operation
    hall_in = 3'd6;
    repeat (3) tick();
    rst = 1'b1;
    #2;
    check("async rst hall_state", hall_state, 3'd0);
    check("async rst position", position, '0);
    check("async rst period", period, '0);
    check("async rst dir", dir, 1'b1);
    hall_in = 3'd2;
    repeat (2) tick();
    rst = 1'b0;
    nsteps = 0;
    repeat (FILT + 2) tick();
    check("after rst hall_state", hall_state, 3'd2);
    check("after rst steps", nsteps, 0);
    check("after rst hall_fault", hall_fault, 1'b0);

    // Position wrap at the signed boundary
    cur = 3'd2;
    clr_pos = 1'b1; tick(); clr_pos = 1'b0;
    check("clr position", position, '0);
    for (int i = 0; i < 127; i++) begin
      cur = seq[(idx_of(cur) + 1) % 6];
      hold(cur, 12);
    end
    check("pos max", position, pw(127));
    cur = seq[(idx_of(cur) + 1) % 6];
    hold(cur, 12);
    check("pos wrap", position, pw(-128));

    // clr_pos on the same edge as a step
    cur = seq[(idx_of(cur) + 1) % 6];
    hall_in = cur;
    repeat (FILT + 1) tick();
    clr_pos = 1'b1;
    tick();
    clr_pos = 1'b0;
    check("clr+step step", step, 1'b1);
    check("clr+step position", position, '0);
    check("clr+step dir", dir, 1'b1);
    repeat (5) tick();

`ifdef HALL_ERR_CNT_EN
    // Error counter saturation and clear
    nserr = 0;
    for (int i = 0; i < 300; i++) begin
      cur = seq[(idx_of(cur) + 2) % 6];
      hold(cur, 12);
    end
    check("errcnt pulses", nserr, 300);
    check("errcnt sat", err_cnt, 8'd255);
    check("errcnt position", position, '0);
    cur = seq[(idx_of(cur) + 2) % 6];
    hall_in = cur;
    repeat (FILT + 1) tick();
    clr_pos = 1'b1;
    tick();
    clr_pos = 1'b0;
    check("clr+err seq_err", seq_err, 1'b1);
    check("clr+err err_cnt", err_cnt, 8'd0);
`endif

    // Randomized stimulus against the reference model
    rst = 1'b1; hall_in = 3'd0;
    repeat (2) tick();
    rst = 1'b0;
    cmp_model = 1'b1;
    cur = seq[$urandom_range(0, 5)];
    for (int s = 0; s < 250; s++) begin
      r  = $urandom_range(0, 99);
      hl = ($urandom_range(0, 49) == 0) ? STALL + 10 : $urandom_range(1, 40);
      if (r < 40)      cur = (idx_of(cur) < 0) ? seq[$urandom_range(0, 5)] : seq[(idx_of(cur) + 1) % 6];
      else if (r < 75) cur = (idx_of(cur) < 0) ? seq[$urandom_range(0, 5)] : seq[(idx_of(cur) + 5) % 6];
      else if (r < 84) cur = seq[$urandom_range(0, 5)];
      else if (r < 89) cur = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'd7;
      else if (r < 95) begin
        hold(3'($urandom_range(0, 7)), $urandom_range(1, FILT - 1));
      end else if (r < 99) begin
        clr_pos = 1'b1; tick(); clr_pos = 1'b0;
      end else begin
        rst = 1'b1; tick(); rst = 1'b0;
      end
      hold(cur, hl);
    end
    cmp_model = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
